instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Upstream stage of the single-cycle MIPS core. Receives a length-prefixed byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes those words through the write port of the program memory.
- Holds the core in reset (cpu_reset) until a complete, valid program has been written, then releases it.

Parameters:
- MEMORY_DEPTH, 32, program memory depth in 32-bit words; maximum accepted word count.
- ADDR_W, $clog2(MEMORY_DEPTH), localparam; width of the word index on mem_addr.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts byte; transfer happens when byte_valid && byte_ready
- mem_we  output  1  program memory write enable, one-cycle pulse
- mem_addr  output  ADDR_W  word index (core PC byte address = mem_addr*4)
- mem_wdata  output  32  instruction word
- cpu_reset  output  1  hold core in reset; drives the core reset input
- busy  output  1  load in progress (LEN_HI, LEN_LO, DATA, CHK)
- done  output  1  program loaded, core released
- error  output  1  load aborted

Behaviour:
- Reset (sync): state=IDLE. cpu_reset=1. byte_ready, mem_we, busy, done, error=0. mem_addr, mem_wdata, counters=0.
- All outputs are registered or decoded directly from the state register; no combinational path from inputs to outputs.
- IDLE: byte_ready=0. start -> LEN_HI; clears done and error.
- LEN_HI / LEN_LO:
  - byte_ready=1. Accept the 16-bit word count N, big-endian.
  - On the LEN_LO transfer: N==0 or N>MEMORY_DEPTH -> ERROR; otherwise -> DATA with word index=0 and byte count=0.
- DATA:
  - byte_ready=1. Each transfer: word={word[23:0],byte_in} (MSB first); byte count increments modulo 4.
  - Transfer of the 4th byte at cycle t: at t+1 mem_we=1 for exactly one cycle, mem_addr=word index, mem_wdata=assembled word. Word index increments.
  - Last word (index N-1) accepted at t: state at t+1 = DONE (or CHK if CHECKSUM_EN). mem_we for that word still pulses at t+1.
- DONE: cpu_reset=0, done=1, byte_ready=0. Both take effect from the first cycle in DONE (t+1 for the last word). State is held until start or reset.
- ERROR: cpu_reset=1, error=1, byte_ready=0. No mem_we. State is held until start or reset.
- cpu_reset=1 in every state except DONE. A start from DONE re-asserts cpu_reset in the next cycle.
- Boundary conditions:
  - byte_valid with byte_ready=0: byte is not consumed, no state change.
  - Idle gaps between bytes: any length, no timeout.
  - start while busy: ignored.
  - start and reset in the same cycle: reset wins.
  - Reset mid-load: returns to IDLE. Already-written words are not cleared. Partial word is discarded.
  - Word index never wraps, because N<=MEMORY_DEPTH is enforced before entering DATA.
- Byte throughput: one byte per cycle sustained.

Optional Feature:
- Macro: INSTRUCTION_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, the loader enters CHK with byte_ready=1 and accepts one checksum byte.
  - The checksum byte must equal the XOR of all data bytes; length bytes are excluded.
  - Match -> DONE. Mismatch -> ERROR; memory already written, cpu_reset stays 1.
  - The running XOR clears on start.
- Undefined: no CHK state, no checksum register; DATA goes straight to DONE.

Decomposition:
- Package loader_pkg:
  - state enum: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERROR
  - LEN_W=16
  - BYTES_PER_WORD=4
- One sub-module: word_assembler.
  - Contains the byte shift register and 2-bit byte counter.
  - Outputs word and word_complete.
  - Has its own clear input, driven on start and reset.

Test Plan:
- Reset held 2 cycles -> cpu_reset=1; byte_ready, mem_we, busy, done, error=0.
- Basic load: start, then bytes 00 02 20 08 00 05 21 29 00 01 back-to-back.
  - Response: mem_we pulse addr0/0x20080005, then addr1/0x21290001.
  - Next cycle after the final byte: done=1, cpu_reset=0, busy=0.
- Oversized length: start, length 00 21 with MEMORY_DEPTH=32 -> error=1, cpu_reset=1, no mem_we. A later start recovers to LEN_HI.
- Stalled stream: same stream as the basic load with byte_valid low 0-3 random cycles between bytes -> identical writes and completion. Bytes presented while byte_ready=0 in IDLE are not consumed.
- Reset during DATA after 5 data bytes -> IDLE, cpu_reset=1, no further mem_we. A fresh full load then succeeds.
- INSTRUCTION_LOADER_CHECKSUM_EN, one word 20 08 00 05:
  - Checksum byte 0x2D -> done=1.
  - Checksum byte 0x2C -> error=1, cpu_reset=1.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM states, length width,
// word geometry and a helper that identifies the states that accept stream bytes.
package loader_pkg;
    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        DONE,
        ERROR
    } state_t;

    function automatic logic is_load_state(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
    endfunction
endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream handshake plus program-memory write port between the loader and its
// neighbours. The loader sits on the slave side; a stream source / memory model on master.
interface instruction_loader_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Collects stream bytes MSB first into 32-bit words. word already includes the byte
// being shifted in, so word_complete and word are valid in the cycle of the 4th byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);
    localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

    logic [SHIFT_W-1:0]    shift_reg;
    logic [SHIFT_W-1:0]    shift_next;
    logic [BYTE_CNT_W-1:0] cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign shift_next[7:0] = byte_in;
            end else begin : g_rest
                assign shift_next[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (shift_en) begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_reg + BYTE_CNT_W'(1);
        end
    end

    assign word          = {shift_reg, byte_in};
    assign word_complete = shift_en && (cnt_reg == BYTE_CNT_W'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/instruction_loader.sv
// Length-prefixed program loader for the MIPS core: writes instruction words to program
// memory and releases cpu_reset once complete. INSTRUCTION_LOADER_CHECKSUM_EN adds a CHK byte.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    instruction_loader_if.slave  bus,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int ADDR_W = $clog2(MEMORY_DEPTH);
    // One extra bit so the index can reach MEMORY_DEPTH without aliasing to 0.
    localparam int IDX_W  = ADDR_W + 1;

    state_t             state_reg;
    logic [7:0]         len_hi_reg;
    logic [IDX_W-1:0]   word_idx_reg;
    logic [IDX_W-1:0]   last_idx_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [31:0]        mem_wdata_reg;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]         xor_reg;
`endif

    logic               xfer;
    logic               start_ok;
    logic [LEN_W-1:0]   len_n;
    logic [31:0]        asm_word;
    logic               asm_complete;

    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
    assign len_n    = {len_hi_reg, bus.byte_in};

    word_assembler u_word_assembler (
        .clk           (clk),
        .clear         (reset || start_ok),
        .shift_en      (xfer && (state_reg == DATA)),
        .byte_in       (bus.byte_in),
        .word          (asm_word),
        .word_complete (asm_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            len_hi_reg    <= '0;
            word_idx_reg  <= '0;
            last_idx_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            xor_reg       <= '0;
`endif
        end else begin
            mem_we_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_reg <= LEN_HI;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        xor_reg   <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi_reg <= bus.byte_in;
                        state_reg  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        word_idx_reg <= '0;
                        last_idx_reg <= IDX_W'(len_n - LEN_W'(1));
                        if ((len_n == '0) || (len_n > LEN_W'(MEMORY_DEPTH)))
                            state_reg <= ERROR;
                        else
                            state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        xor_reg <= xor_reg ^ bus.byte_in;
`endif
                        if (asm_complete) begin
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= word_idx_reg[ADDR_W-1:0];
                            mem_wdata_reg <= asm_word;
                            word_idx_reg  <= word_idx_reg + IDX_W'(1);
                            if (word_idx_reg == last_idx_reg) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                                state_reg <= CHK;
`else
                                state_reg <= DONE;
`endif
                            end
                        end
                    end
                end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer)
                        state_reg <= (bus.byte_in == xor_reg) ? DONE : ERROR;
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Status outputs decode straight from the state register.
    assign busy           = is_load_state(state_reg);
    assign bus.byte_ready = is_load_state(state_reg);
    assign cpu_reset      = (state_reg != DONE);
    assign done           = (state_reg == DONE);
    assign error          = (state_reg == ERROR);
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed and randomized loads compared
// against a stream-level reference model of the expected memory writes and outcome.
`timescale 1ns/1ps
module tb_instruction_loader;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset, busy, done, error;

    instruction_loader_if #(.ADDR_W(AW)) bus();

    instruction_loader #(.MEMORY_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic          exp_err;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: parse the stream as the loader protocol describes it.
    task automatic model(input bq_t s);
        int n;
        exp_addr.delete();
        exp_data.delete();
        n = {s[0], s[1]};
        exp_err = (n == 0) || (n > DEPTH);
        if (!exp_err) begin
            for (int w = 0; w < n; w++) begin
                exp_addr.push_back(AW'(w));
                exp_data.push_back({s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                for (int i = 2; i < 2 + 4*n; i++) x = x ^ s[i];
                if (s[2+4*n] != x) exp_err = 1'b1;
            end
`endif
        end
    endtask

    task automatic make_stream(input int n, input bit bad_chk, output bq_t s);
        logic [7:0] b;
        logic [7:0] x;
        s = {};
        x = 8'h00;
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < 4*n; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                s.push_back(b);
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            s.push_back(bad_chk ? (x ^ 8'h01) : x);
`else
            if (bad_chk) x = 8'h00;
`endif
        end
    endtask

    // Called at a negedge; returns at the negedge following the consuming posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        guard = 0;
        while (!bus.byte_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_val("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string name, input bq_t s, input int maxgap, input int start_at);
        model(s);
        got_addr.delete();
        got_data.delete();
        pulse_start();
        check_val({name, "_busy_after_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < s.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(s[i], $urandom_range(maxgap, 0));
        end
        bus.byte_valid = 1'b0;
        check_val({name, "_done"},      32'(done),           32'(!exp_err));
        check_val({name, "_error"},     32'(error),          32'(exp_err));
        check_val({name, "_cpu_reset"}, 32'(cpu_reset),      32'(exp_err));
        check_val({name, "_busy_end"},  32'(busy),           32'd0);
        check_val({name, "_ready_end"}, 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_val({name, "_write_count"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check_val({name, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
            check_val({name, "_data"}, got_data[i], exp_data[i]);
        end
        check_val({name, "_done_held"}, 32'(done), 32'(!exp_err));
        $display("load %s: %0d bytes, %0d writes, expect_err=%0b", name, s.size(), got_data.size(), exp_err);
    endtask

    initial begin
        bq_t basic;
        bq_t s;
        int  n;

        reset = 1'b1;
        start = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_cpu_reset",  32'(cpu_reset),      32'd1);
        check_val("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check_val("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check_val("rst_busy",       32'(busy),           32'd0);
        check_val("rst_done",       32'(done),           32'd0);
        check_val("rst_error",      32'(error),          32'd0);
        reset = 1'b0;
        @(negedge clk);

        basic = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'h00, 8'h01};
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        basic.push_back(8'h20 ^ 8'h08 ^ 8'h00 ^ 8'h05 ^ 8'h21 ^ 8'h29 ^ 8'h00 ^ 8'h01);
`endif
        run_load("basic", basic, 0, -1);
        check_val("basic_word0", exp_data[0], 32'h2008_0005);
        check_val("basic_word1", exp_data[1], 32'h2129_0001);

        s = '{8'h00, 8'h21};
        run_load("oversize", s, 0, -1);
        pulse_start();
        check_val("recover_busy",  32'(busy),           32'd1);
        check_val("recover_ready", 32'(bus.byte_ready), 32'd1);
        check_val("recover_error", 32'(error),          32'd0);
        run_load("after_recover", basic, 1, -1);

        s = '{8'h00, 8'h00};
        run_load("zero_len", s, 0, -1);

        // Return to IDLE, then present bytes that must not be consumed.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.byte_in    = 8'hAA;
        bus.byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        check_val("idle_ready", 32'(bus.byte_ready), 32'd0);
        check_val("idle_busy",  32'(busy),           32'd0);
        run_load("stalled", basic, 3, -1);

        run_load("start_while_busy", basic, 2, 5);

        // Reset in the middle of DATA after 5 data bytes.
        got_addr.delete();
        got_data.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(basic[i], 0);
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("midrst_busy",      32'(busy),           32'd0);
        check_val("midrst_cpu_reset", 32'(cpu_reset),      32'd1);
        check_val("midrst_ready",     32'(bus.byte_ready), 32'd0);
        bus.byte_in    = 8'h55;
        bus.byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.byte_valid = 1'b0;
        check_val("midrst_writes", 32'(got_data.size()), 32'd1);
        check_val("midrst_word0",  got_data[0],          32'h2008_0005);
        check_val("midrst_still_idle", 32'(busy),        32'd0);
        run_load("after_midrst", basic, 0, -1);

        // Reset and start asserted together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_val("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        run_load("chk_good", s, 0, -1);
        check_val("chk_good_done", 32'(done), 32'd1);
        s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        run_load("chk_bad", s, 0, -1);
        check_val("chk_bad_error", 32'(error),     32'd1);
        check_val("chk_bad_cpurst", 32'(cpu_reset), 32'd1);
`endif

        make_stream(DEPTH, 1'b0, s);
        run_load("full_depth", s, 1, -1);

        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(5, 0))
                0:       n = DEPTH + 1 + int'($urandom_range(300, 0));
                default: n = int'($urandom_range(6, 1));
            endcase
            make_stream(n, ($urandom_range(3, 0) == 0), s);
            run_load($sformatf("rand%0d", it), s, 3, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
